// File: rtl/multi_divider_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Mode encodings and channel sequencing states are used by the channel and the top.
`timescale 1ns/1ps
package multi_divider_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } div_mode_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  localparam int MAX_CH = 16;

endpackage

// File: rtl/multi_divider_channel.sv
// One divider channel: counter, live ratio/mode, shadow update slot and registered output.
// Updates arriving while the channel runs are held until the next period boundary.
`timescale 1ns/1ps
module multi_divider_channel
  import multi_divider_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync,
  input  logic             ld_valid,
  input  logic [DIV_W-1:0] ld_div,
  input  logic             ld_mode,
  output logic             pending,
  output logic             out
);

  localparam int HW = DIV_W + 1;

  ch_state_t        state_reg, state_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [DIV_W-1:0] div_reg, div_next;
  div_mode_t        mode_reg, mode_next;
  logic [DIV_W-1:0] shadow_div_reg, shadow_div_next;
  div_mode_t        shadow_mode_reg, shadow_mode_next;
  logic             pending_reg, pending_next;
  logic             out_reg, out_next;

  logic active;
  logic wrap;
  logic boundary;

  // Output level for count c within a period of n; the half-period sum is one bit wider
  // so that n at full scale still rounds up correctly.
  function automatic logic wave(input logic [DIV_W-1:0] c, input logic [DIV_W-1:0] n,
                                input div_mode_t m);
    logic [HW-1:0] half;
    logic          level;
    half = ({1'b0, n} + HW'(1)) >> 1;
    if (n == '0)
      level = 1'b0;
    else if (m == MODE_PULSE)
      level = (c == n - DIV_W'(1));
    else
      level = ({1'b0, c} < half);
    return level;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= CH_IDLE;
      cnt_reg         <= '0;
      div_reg         <= '0;
      mode_reg        <= MODE_SQUARE;
      shadow_div_reg  <= '0;
      shadow_mode_reg <= MODE_SQUARE;
      pending_reg     <= 1'b0;
      out_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      div_reg         <= div_next;
      mode_reg        <= mode_next;
      shadow_div_reg  <= shadow_div_next;
      shadow_mode_reg <= shadow_mode_next;
      pending_reg     <= pending_next;
      out_reg         <= out_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    div_next         = div_reg;
    mode_next        = mode_reg;
    shadow_div_next  = shadow_div_reg;
    shadow_mode_next = shadow_mode_reg;
    pending_next     = pending_reg;
    out_next         = out_reg;

    active   = enable && (div_reg != '0);
    wrap     = (state_reg == CH_RUN) && (cnt_reg == div_reg - DIV_W'(1));
    boundary = (state_reg == CH_IDLE) || sync || wrap;

    if (!active) begin
      state_next = CH_IDLE;
      cnt_next   = '0;
      out_next   = 1'b0;
      if (pending_reg) begin
        div_next     = shadow_div_reg;
        mode_next    = shadow_mode_reg;
        pending_next = 1'b0;
      end else if (ld_valid) begin
        div_next  = ld_div;
        mode_next = div_mode_t'(ld_mode);
      end
    end else begin
      state_next = CH_RUN;
      if (boundary) begin
        cnt_next = '0;
        if (pending_reg) begin
          div_next     = shadow_div_reg;
          mode_next    = shadow_mode_reg;
          pending_next = 1'b0;
        end
        out_next = wave('0, div_next, mode_next);
      end else begin
        cnt_next = cnt_reg + DIV_W'(1);
        out_next = wave(cnt_next, div_reg, mode_reg);
      end
      // A request accepted on a wrap edge waits for the following boundary.
      if (ld_valid) begin
        shadow_div_next  = ld_div;
        shadow_mode_next = div_mode_t'(ld_mode);
        pending_next     = 1'b1;
      end
    end
  end

  assign pending = pending_reg;
  assign out     = out_reg;

endmodule

// File: rtl/multi_divider.sv
// NUM_CH-channel programmable divider: config decode, ready mux and the channel array.
// Requests addressed beyond the last channel see ready=1 and are silently dropped.
`timescale 1ns/1ps
module multi_divider
  import multi_divider_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              sync_all,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] out
);

  localparam int SLOTS = 1 << CH_W;

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ld_valid;
  logic [SLOTS-1:0]  pending_slot;

  // Unused slots read as never pending, which makes out-of-range channels always ready.
  always_comb begin
    pending_slot             = '0;
    pending_slot[NUM_CH-1:0] = pending;
  end

  assign cfg_ready = !pending_slot[cfg_ch];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ld_valid[gi] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));

      multi_divider_channel #(
        .DIV_W(DIV_W)
      ) u_channel (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable[gi]),
        .sync    (sync_all),
        .ld_valid(ld_valid[gi]),
        .ld_div  (cfg_div),
        .ld_mode (cfg_mode),
        .pending (pending[gi]),
        .out     (out[gi])
      );
    end
  endgenerate

endmodule
